sad_accum: RTL and testbench

Downstream consumer of the SAD pipeline's valid/ready result stream. It accepts per-pixel-pair SAD results and sums each block of 2^N_LOG2 consecutive results into a block SAD. Each block SAD is emitted on its own valid/ready output together with a wrapping block index. It drives backpressure toward the pipeline's `rdy_dn` and sits between the pipeline and motion-search control logic.

---
 rtl/sad_accum.sv | 129 ++++++++++++
 tb/tb_sad_accum.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_accum.sv
// sad_accum: sums each block of 2^N_LOG2 consecutive SAD results into a block
// SAD and presents it on a valid/ready output together with a wrapping block
// index. At most one block sum is buffered; input backpressure is applied only
// while that sum is pending and the consumer is not ready.
// Optional feature macro: SAD_ACCUM_MIN_EN (tracks the smallest block SAD and
// its index since reset/clr; when undefined, min_sum/min_idx are tied to 0).
module sad_accum #(
    parameter int W      = 8,
    parameter int N_LOG2 = 4,
    parameter int IDX_W  = 8,
    localparam int ACC_W = W + 2 + N_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [W+1:0]     in_data,
    output logic             in_rdy,
    input  logic             clr,
    output logic             out_vld,
    output logic [ACC_W-1:0] out_sum,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_rdy,
    output logic [ACC_W-1:0] min_sum,
    output logic [IDX_W-1:0] min_idx
);

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [0:0]        state;
    logic [ACC_W-1:0]  acc;
    logic [N_LOG2-1:0] cnt;
    logic [IDX_W-1:0]  blk;

    logic              in_hs;
    logic              out_hs;
    logic              last;
    logic              done;
    logic              occupied_next;
    logic [ACC_W-1:0]  sum_next;

    // The accept decision never looks at in_vld, so the upstream pipeline can
    // use in_rdy to decide whether to advance without a combinational loop.
    assign in_rdy        = ~clr & ((state == ACC) | out_rdy);
    assign in_hs         = in_vld & in_rdy;
    assign out_hs        = out_vld & out_rdy;
    assign last          = (cnt == {N_LOG2{1'b1}});
    assign done          = in_hs & last;
    assign sum_next      = acc + ACC_W'(in_data);
    // The output register stays busy if a new block lands in it, or if the
    // sum already there is not taken this cycle.
    assign occupied_next = done | (out_vld & ~out_rdy);

    // Control: FULL whenever a block sum sits unconsumed in the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else if (clr) begin
            state <= ACC;
        end else begin
            state <= occupied_next ? FULL : ACC;
        end
    end

    // Running block accumulator, position within the block and block index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            blk <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
            blk <= '0;
        end else if (in_hs) begin
            cnt <= cnt + N_LOG2'(1);
            if (last) begin
                acc <= '0;
                blk <= blk + IDX_W'(1);
            end else begin
                acc <= sum_next;
            end
        end
    end

    // Output register: a completing block overwrites whatever is presented, so
    // a same-cycle drain and refill leaves out_vld high with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_sum <= '0;
            out_idx <= '0;
        end else if (clr) begin
            out_vld <= 1'b0;
        end else if (done) begin
            out_vld <= 1'b1;
            out_sum <= sum_next;
            out_idx <= blk;
        end else if (out_hs) begin
            out_vld <= 1'b0;
        end
    end

`ifdef SAD_ACCUM_MIN_EN
    logic [ACC_W-1:0] min_sum_q;
    logic [IDX_W-1:0] min_idx_q;

    // Minimum tracker: strict compare so a tie keeps the earlier block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_sum_q <= '1;
            min_idx_q <= '0;
        end else if (clr) begin
            min_sum_q <= '1;
            min_idx_q <= '0;
        end else if (done && (sum_next < min_sum_q)) begin
            min_sum_q <= sum_next;
            min_idx_q <= blk;
        end
    end

    assign min_sum = min_sum_q;
    assign min_idx = min_idx_q;
`else
    assign min_sum = '0;
    assign min_idx = '0;
`endif

endmodule

// File: tb/tb_sad_accum.sv
// tb_sad_accum: directed table vectors, hand-written corner sequences and a
// randomized run for sad_accum (W=8, N_LOG2=2, IDX_W=8), each cycle checked
// against a block-level reference model.
module tb_sad_accum;

    localparam int W      = 8;
    localparam int N_LOG2 = 2;
    localparam int IDX_W  = 8;
    localparam int ACC_W  = W + 2 + N_LOG2;
    localparam int BLK    = 1 << N_LOG2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_vld = 1'b0;
    logic [W+1:0]     in_data = '0;
    logic             in_rdy;
    logic             clr = 1'b0;
    logic             out_vld;
    logic [ACC_W-1:0] out_sum;
    logic [IDX_W-1:0] out_idx;
    logic             out_rdy = 1'b0;
    logic [ACC_W-1:0] min_sum;
    logic [IDX_W-1:0] min_idx;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_vld;
    int m_sum, m_idx, m_blk, cur_sum, cur_n, m_min, m_min_idx;

    sad_accum #(.W(W), .N_LOG2(N_LOG2), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
        .clr(clr),
        .out_vld(out_vld), .out_sum(out_sum), .out_idx(out_idx), .out_rdy(out_rdy),
        .min_sum(min_sum), .min_idx(min_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vld     = 0;
        m_sum     = 0;
        m_idx     = 0;
        m_blk     = 0;
        cur_sum   = 0;
        cur_n     = 0;
        m_min     = (1 << ACC_W) - 1;
        m_min_idx = 0;
    endtask

    function automatic int exp_min_sum();
`ifdef SAD_ACCUM_MIN_EN
        return m_min;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_min_idx();
`ifdef SAD_ACCUM_MIN_EN
        return m_min_idx;
`else
        return 0;
`endif
    endfunction

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_min_sum", min_sum, exp_min_sum());
        chk("rst_min_idx", min_idx, exp_min_idx());
        in_vld  = 1'b0;
        clr     = 1'b0;
        out_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step(input logic v, input logic [W+1:0] d, input logic r, input logic c);
        bit exp_rdy;
        @(negedge clk);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        clr     = c;
        #1;
        exp_rdy = !c && (!m_vld || r);
        chk("in_rdy", in_rdy, exp_rdy);
        chk("out_vld", out_vld, m_vld);
        if (m_vld) begin
            chk("out_sum", out_sum, m_sum);
            chk("out_idx", out_idx, m_idx);
        end
        chk("min_sum", min_sum, exp_min_sum());
        chk("min_idx", min_idx, exp_min_idx());
        if (c) begin
            model_reset();
        end else begin
            if (m_vld && r) m_vld = 0;
            if (v && exp_rdy) begin
                cur_sum += int'(d);
                cur_n++;
                if (cur_n == BLK) begin
                    m_vld = 1;
                    m_sum = cur_sum;
                    m_idx = m_blk;
                    if (cur_sum < m_min) begin
                        m_min     = cur_sum;
                        m_min_idx = m_blk;
                    end
                    m_blk   = (m_blk + 1) % (1 << IDX_W);
                    cur_sum = 0;
                    cur_n   = 0;
                end
            end
        end
    endtask

    typedef struct {
        bit       rst;
        bit       v;
        int       d;
        bit       r;
        bit       c;
        bit       e_rdy;
        bit       e_vld;
        int       e_sum;
        int       e_idx;
    } vec_t;

    vec_t tbl[25];

    initial begin
        // rst  v   d   r  c   rdy vld sum idx
        tbl[0]  = '{1, 1, 10, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 20, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 30, 1, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 1, 40, 1, 0, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 0,  1, 0, 1, 1, 100, 0};
        tbl[5]  = '{0, 0, 0,  1, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 10, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 20, 1, 0, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 30, 1, 0, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 40, 1, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 1, 1,  0, 0, 0, 1, 100, 0};
        tbl[11] = '{0, 1, 1,  0, 0, 0, 1, 100, 0};
        tbl[12] = '{0, 1, 1,  1, 0, 1, 1, 100, 0};
        tbl[13] = '{0, 1, 2,  1, 0, 1, 0, 0, 0};
        tbl[14] = '{0, 1, 3,  1, 0, 1, 0, 0, 0};
        tbl[15] = '{0, 1, 4,  1, 0, 1, 0, 0, 0};
        tbl[16] = '{0, 0, 0,  1, 0, 1, 1, 10, 1};
        tbl[17] = '{1, 1, 3,  1, 0, 1, 0, 0, 0};
        tbl[18] = '{0, 1, 3,  1, 0, 1, 0, 0, 0};
        tbl[19] = '{0, 1, 99, 1, 1, 0, 0, 0, 0};
        tbl[20] = '{0, 1, 5,  1, 0, 1, 0, 0, 0};
        tbl[21] = '{0, 1, 5,  1, 0, 1, 0, 0, 0};
        tbl[22] = '{0, 1, 5,  1, 0, 1, 0, 0, 0};
        tbl[23] = '{0, 1, 5,  1, 0, 1, 0, 0, 0};
        tbl[24] = '{0, 0, 0,  1, 0, 1, 1, 20, 0};

        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: first block, stall/resume, clr mid-block.
        for (int i = 0; i < 25; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].v, (W+2)'(tbl[i].d), tbl[i].r, tbl[i].c);
            chk($sformatf("tbl%0d_in_rdy", i), in_rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_out_vld", i), out_vld, tbl[i].e_vld);
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_out_sum", i), out_sum, tbl[i].e_sum);
                chk($sformatf("tbl%0d_out_idx", i), out_idx, tbl[i].e_idx);
            end
        end

        // Back-to-back maximum-value results, no bubbles.
        do_reset();
        for (int s = 0; s < 8; s++) begin
            step(1, 10'd510, 1, 0);
            if (s == 4) begin
                chk("b2b_vld0", out_vld, 1);
                chk("b2b_sum0", out_sum, 2040);
                chk("b2b_idx0", out_idx, 0);
            end
        end
        step(0, 0, 1, 0);
        chk("b2b_sum1", out_sum, 2040);
        chk("b2b_idx1", out_idx, 1);

        // Minimum tracking with a tie: 100, 60, 60, 80.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 4; s++) begin
                int val;
                case (b)
                    0: val = 10 * (s + 1);
                    1, 2: val = 15;
                    default: val = 20;
                endcase
                step(1, (W+2)'(val), 1, 0);
            end
        end
        step(0, 0, 1, 0);
`ifdef SAD_ACCUM_MIN_EN
        chk("min_sum_final", min_sum, 60);
        chk("min_idx_final", min_idx, 1);
`else
        chk("min_sum_final", min_sum, 0);
        chk("min_idx_final", min_idx, 0);
`endif

        // Block index wrap after 256 blocks.
        do_reset();
        for (int s = 0; s < 257 * BLK; s++) begin
            step(1, (W+2)'($urandom_range(0, 1023)), 1, 0);
            if (s == 256 * BLK) chk("wrap_idx_255", out_idx, 255);
        end
        step(0, 0, 1, 0);
        chk("wrap_vld", out_vld, 1);
        chk("wrap_idx_0", out_idx, 0);

        // Reset with a stalled sum, then reset mid-block.
        do_reset();
        for (int s = 0; s < 4; s++) step(1, 10'd7, 1, 0);
        step(0, 0, 0, 0);
        chk("stall_before_rst", out_vld, 1);
        do_reset();
        step(1, 10'd9, 1, 0);
        step(1, 10'd9, 1, 0);
        do_reset();
        for (int s = 0; s < 4; s++) step(1, 10'd7, 1, 0);
        step(0, 0, 1, 0);
        chk("post_rst_sum", out_sum, 28);
        chk("post_rst_idx", out_idx, 0);

        // Randomized traffic with occasional clr.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 3) != 0), (W+2)'($urandom_range(0, 1023)),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
